// File: rtl/layer2_mac_sequencer_pkg.sv
// Shared definitions for the layer-2 MAC sequencer: FSM state encoding and default widths.
package layer2_mac_sequencer_pkg;

    localparam int unsigned DefaultReluNodes      = 16;
    localparam int unsigned DefaultReluIndexWidth = 5;
    localparam int unsigned DefaultInWidth        = 8;
    localparam int unsigned DefaultOutNodes       = 4;
    localparam int unsigned DefaultWWidth         = 8;
    localparam int unsigned DefaultAccWidth       = 24;

    typedef enum logic [2:0] {
        StIdle,
        StDeqHi,
        StDeqLo,
        StFetch,
        StMac,
        StFin
    } seqState_t;

endpackage

// File: rtl/layer2_mac_sequencer_if.sv
// Queue, weight-storage and result signals of the layer-2 MAC sequencer.
interface layer2_mac_sequencer_if
    import layer2_mac_sequencer_pkg::*;
#(
    parameter int unsigned RELU_INDEX_WIDTH = DefaultReluIndexWidth,
    parameter int unsigned IN_WIDTH         = DefaultInWidth,
    parameter int unsigned OUT_NODES        = DefaultOutNodes,
    parameter int unsigned W_WIDTH          = DefaultWWidth,
    parameter int unsigned ACC_WIDTH        = DefaultAccWidth
);

    logic                              start;
    logic                              queueEmpty;
    logic [RELU_INDEX_WIDTH-1:0]       indexIn;
    logic [IN_WIDTH-1:0]               nodeValueIn;
    logic                              dequeue;
    logic [RELU_INDEX_WIDTH-1:0]       weightAddr;
    logic [OUT_NODES*W_WIDTH-1:0]      weightsIn;
    logic [OUT_NODES*ACC_WIDTH-1:0]    accOut;
    logic                              busy;
    logic                              done;

    modport master (
        input  start, queueEmpty, indexIn, nodeValueIn, weightsIn,
        output dequeue, weightAddr, accOut, busy, done
    );

    modport slave (
        output start, queueEmpty, indexIn, nodeValueIn, weightsIn,
        input  dequeue, weightAddr, accOut, busy, done
    );

endinterface

// File: rtl/layer2_mac_lane.sv
// One signed multiply-accumulate lane: acc += sext({0,value}) * weight, wrapping, with clear.
module layer2_mac_lane #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned W_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        enable,
    input  logic [IN_WIDTH-1:0]         value,
    input  logic signed [W_WIDTH-1:0]   weight,
    output logic signed [ACC_WIDTH-1:0] acc
);

    localparam int unsigned ProdWidth = IN_WIDTH + W_WIDTH + 1;

    logic signed [IN_WIDTH:0]      valueSigned;
    logic signed [ProdWidth-1:0]   product;

    // Node values are unsigned; a zero MSB keeps them positive in the signed multiply.
    assign valueSigned = {1'b0, value};
    assign product     = ProdWidth'(valueSigned) * ProdWidth'(weight);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

endmodule

// File: rtl/layer2_mac_sequencer.sv
// Layer-2 MAC sequencer: drains a ReLU queue and accumulates weighted sums per output node.
// Optional macro ZERO_SKIP_EN: zero-valued entries skip the weight fetch and MAC.
module layer2_mac_sequencer
    import layer2_mac_sequencer_pkg::*;
#(
    parameter int unsigned RELU_NODES       = DefaultReluNodes,
    parameter int unsigned RELU_INDEX_WIDTH = DefaultReluIndexWidth,
    parameter int unsigned IN_WIDTH         = DefaultInWidth,
    parameter int unsigned OUT_NODES        = DefaultOutNodes,
    parameter int unsigned W_WIDTH          = DefaultWWidth,
    parameter int unsigned ACC_WIDTH        = DefaultAccWidth
) (
    input  logic                   clk,
    input  logic                   reset,
    layer2_mac_sequencer_if.master bus
);

    seqState_t                   stateQ;
    logic                        dequeueQ;
    logic                        busyQ;
    logic                        doneQ;
    logic [RELU_INDEX_WIDTH-1:0] countQ;
    logic [RELU_INDEX_WIDTH-1:0] indexQ;
    logic [IN_WIDTH-1:0]         valueQ;

    logic [RELU_INDEX_WIDTH-1:0]    countNext;
    logic                           lastItem;
    logic                           accClear;
    logic                           macEnable;
    logic [OUT_NODES*ACC_WIDTH-1:0] accFlat;

    assign countNext = countQ + 1'b1;
    assign lastItem  = bus.queueEmpty || (countNext == RELU_INDEX_WIDTH'(RELU_NODES));
    assign accClear  = (stateQ == StIdle) && bus.start;
    assign macEnable = (stateQ == StMac);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= StIdle;
            dequeueQ <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            countQ   <= '0;
            indexQ   <= '0;
            valueQ   <= '0;
        end else begin
            dequeueQ <= 1'b0;
            doneQ    <= 1'b0;
            unique case (stateQ)
                StIdle: begin
                    if (bus.start) begin
                        countQ <= '0;
                        busyQ  <= 1'b1;
                        if (bus.queueEmpty) begin
                            stateQ <= StFin;
                        end else begin
                            stateQ   <= StDeqHi;
                            dequeueQ <= 1'b1;
                        end
                    end
                end
                StDeqHi: stateQ <= StDeqLo;
                StDeqLo: begin
                    indexQ <= bus.indexIn;
                    valueQ <= bus.nodeValueIn;
`ifdef ZERO_SKIP_EN
                    // A zero contributes nothing, so count it and move straight on.
                    if (bus.nodeValueIn == '0) begin
                        countQ <= countNext;
                        if (lastItem) begin
                            stateQ <= StFin;
                        end else begin
                            stateQ   <= StDeqHi;
                            dequeueQ <= 1'b1;
                        end
                    end else begin
                        stateQ <= StFetch;
                    end
`else
                    stateQ <= StFetch;
`endif
                end
                StFetch: stateQ <= StMac;
                StMac: begin
                    countQ <= countNext;
                    if (lastItem) begin
                        stateQ <= StFin;
                    end else begin
                        stateQ   <= StDeqHi;
                        dequeueQ <= 1'b1;
                    end
                end
                StFin: begin
                    doneQ  <= 1'b1;
                    busyQ  <= 1'b0;
                    indexQ <= '0;
                    stateQ <= StIdle;
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    // Node 0 sits in the MSBs of both the weight row and the accumulator bus.
    for (genvar k = 0; k < OUT_NODES; k++) begin : gLane
        layer2_mac_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .W_WIDTH   (W_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) uLane (
            .clk    (clk),
            .reset  (reset),
            .clear  (accClear),
            .enable (macEnable),
            .value  (valueQ),
            .weight (bus.weightsIn[(OUT_NODES-1-k)*W_WIDTH +: W_WIDTH]),
            .acc    (accFlat[(OUT_NODES-1-k)*ACC_WIDTH +: ACC_WIDTH])
        );
    end

    assign bus.dequeue    = dequeueQ;
    assign bus.busy       = busyQ;
    assign bus.done       = doneQ;
    assign bus.weightAddr = indexQ;
    assign bus.accOut     = accFlat;

endmodule

// File: tb/tb_layer2_mac_sequencer.sv
// Self-checking bench for layer2_mac_sequencer against a queue/ROM reference model.
module tb_layer2_mac_sequencer;

    typedef struct {
        logic [4:0] idx;
        logic [7:0] val;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    layer2_mac_sequencer_if bus ();

    layer2_mac_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    entry_t      fifo[$];
    logic [31:0] rom[32];
    int          vectors     = 0;
    int          miscompares = 0;

    // Queue model: presents and pops the head on each rising dequeue edge.
    always @(posedge bus.dequeue) begin
        if (fifo.size() > 0) begin
            bus.indexIn     = fifo[0].idx;
            bus.nodeValueIn = fifo[0].val;
            void'(fifo.pop_front());
        end
        bus.queueEmpty = (fifo.size() == 0);
    end

    // Weight storage with a one-cycle read latency.
    always @(posedge clk) bus.weightsIn <= rom[bus.weightAddr];

    task automatic checkValue(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pushEntry(input int idx, input int val);
        entry_t e;
        e.idx = 5'(idx);
        e.val = 8'(val);
        fifo.push_back(e);
        bus.queueEmpty = 1'b0;
    endtask

    task automatic flushQueue();
        fifo.delete();
        bus.queueEmpty = 1'b1;
    endtask

    function automatic longint laneOut(input int k);
        logic [95:0] a;
        a = bus.accOut;
        return longint'(a[(3-k)*24 +: 24]);
    endfunction

    // Runs one load; lateStart > 0 pulses a second start at that cycle.
    task automatic runLoad(input string name, input int lateStart);
        entry_t      snap[$];
        longint      expAcc[4];
        logic [7:0]  w8;
        int          wv, n, expLat, minGapReq;
        int          doneAt, deqCount, lastDeq, minGap, busyLow, busyAtDone;
        snap = fifo;
        n = (snap.size() < 16) ? snap.size() : 16;
        expLat = 2;
        for (int k = 0; k < 4; k++) expAcc[k] = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                w8 = rom[snap[i].idx][(3-k)*8 +: 8];
                wv = $signed(w8);
                expAcc[k] += longint'(snap[i].val) * longint'(wv);
            end
`ifdef ZERO_SKIP_EN
            expLat += (snap[i].val == 0) ? 2 : 4;
`else
            expLat += 4;
`endif
        end
`ifdef ZERO_SKIP_EN
        minGapReq = 2;
`else
        minGapReq = 4;
`endif
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        doneAt = -1; deqCount = 0; lastDeq = -100; minGap = 1000; busyLow = 0; busyAtDone = 0;
        for (int j = 1; j <= 200; j++) begin
            if (j == lateStart) bus.start = 1'b1;
            else if (lateStart > 0 && j == lateStart + 1) bus.start = 1'b0;
            if (bus.dequeue) begin
                deqCount++;
                if (j - lastDeq < minGap) minGap = j - lastDeq;
                lastDeq = j;
            end
            if (bus.done) begin
                doneAt = j;
                busyAtDone = int'(bus.busy);
                break;
            end
            if (!bus.busy) busyLow++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkValue({name, ".doneSeen"}, longint'(doneAt > 0), 1);
        checkValue({name, ".latency"}, doneAt, expLat);
        checkValue({name, ".dequeues"}, deqCount, n);
        checkValue({name, ".busyLow"}, busyLow, 0);
        checkValue({name, ".busyAtDone"}, busyAtDone, 0);
        if (n >= 2) checkValue({name, ".deqGapOk"}, longint'(minGap >= minGapReq), 1);
        for (int k = 0; k < 4; k++)
            checkValue($sformatf("%s.acc%0d", name, k), laneOut(k), expAcc[k] & 64'hFFFFFF);
        // Done is a single pulse and the FSM stays idle afterwards.
        deqCount = 0;
        @(negedge clk);
        checkValue({name, ".donePulse"}, longint'(bus.done), 0);
        for (int j = 0; j < 5; j++) begin
            if (bus.dequeue || bus.busy || bus.done || bus.weightAddr != 0) deqCount++;
            @(negedge clk);
        end
        checkValue({name, ".idleQuiet"}, deqCount, 0);
        checkValue({name, ".accHold0"}, laneOut(0), expAcc[0] & 64'hFFFFFF);
        flushQueue();
    endtask

    initial begin
        int seen;
        bus.start       = 1'b0;
        bus.queueEmpty  = 1'b1;
        bus.indexIn     = '0;
        bus.nodeValueIn = '0;
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkValue("rst.dequeue", longint'(bus.dequeue), 0);
        checkValue("rst.busy", longint'(bus.busy), 0);
        checkValue("rst.done", longint'(bus.done), 0);
        checkValue("rst.weightAddr", longint'(bus.weightAddr), 0);
        checkValue("rst.accOut", longint'(bus.accOut == 0), 1);
        reset = 1'b0;
        @(negedge clk);

        // Sixteen ones against weight 2 on every lane.
        for (int i = 0; i < 32; i++) rom[i] = 32'h02020202;
        for (int i = 0; i < 16; i++) pushEntry(i, 1);
        runLoad("full", 0);

        // Signed extremes on a single entry.
        rom[3] = 32'h807FFF00;
        pushEntry(3, 255);
        runLoad("signed", 0);

        // Empty queue: straight to done, accumulators cleared.
        runLoad("empty", 0);

        // A second start mid-load is ignored; extra entries stay queued.
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        for (int i = 0; i < 20; i++) pushEntry($urandom_range(0, 31), $urandom_range(0, 255));
        runLoad("busyStart", 10);

        // Alternating zeros give the same sums with or without zero skipping.
        for (int i = 0; i < 32; i++) rom[i] = 32'h01010101;
        for (int i = 0; i < 16; i++) pushEntry(i, (i % 2 == 0) ? 0 : 3);
        runLoad("zeroSkip", 0);

        // Randomized loads, including short queues that empty early.
        for (int t = 0; t < 6; t++) begin
            int sz;
            for (int i = 0; i < 32; i++) rom[i] = $urandom;
            sz = $urandom_range(1, 20);
            for (int i = 0; i < sz; i++)
                pushEntry($urandom_range(0, 31), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
            runLoad($sformatf("rand%0d", t), 0);
        end

        // Reset during the second dequeue pulse, after partial sums exist.
        rom[0] = 32'h01020304;
        for (int i = 0; i < 5; i++) pushEntry(0, 7);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        seen = 0;
        for (int j = 0; j < 40 && seen < 2; j++) begin
            if (bus.dequeue) seen++;
            if (seen < 2) @(negedge clk);
        end
        checkValue("rstMid.reached", seen, 2);
        checkValue("rstMid.accBefore", longint'(laneOut(3) != 0), 1);
        reset = 1'b1;
        #1;
        checkValue("rstMid.dequeue", longint'(bus.dequeue), 0);
        checkValue("rstMid.accOut", longint'(bus.accOut == 0), 1);
        checkValue("rstMid.busy", longint'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (bus.dequeue || bus.busy || bus.weightAddr != 0) seen++;
        end
        checkValue("rstMid.idleAfter", seen, 0);
        flushQueue();
        for (int i = 0; i < 3; i++) pushEntry(0, 7);
        runLoad("afterRst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
